// File: rtl/wam_pkg.sv
// Shared constants, state encoding and LFSR/hole helpers for the whac-a-mole mole generator.
package wam_pkg;

    localparam int N_HOLE = 8;
    localparam int HOLE_W = 3;
    localparam logic [7:0] LFSR_MASK = 8'hB8;

    typedef enum logic [1:0] {
        GAP  = 2'd0,
        PICK = 2'd1,
        UP   = 2'd2
    } state_t;

    // Fibonacci step for x^8+x^6+x^5+x^4+1; feedback enters at bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_MASK)};
    endfunction

    // Bumping a repeated candidate to the next hole keeps consecutive moles apart.
    function automatic logic [HOLE_W-1:0] pick_hole(input logic [7:0] rnd,
                                                    input logic [HOLE_W-1:0] prev);
        logic [HOLE_W-1:0] cand;
        cand = rnd[HOLE_W-1:0];
        return (cand != prev) ? cand : HOLE_W'(cand + 1'b1);
    endfunction

endpackage

// File: rtl/wam_mol_if.sv
// Tap bus in, mole LEDs and hit/miss pulses out; the score counter listens on the slave side.
interface wam_mol_if;
    import wam_pkg::*;

    logic [N_HOLE-1:0] tap;
    logic [N_HOLE-1:0] mole;
    logic [N_HOLE-1:0] hit;
    logic              miss;

    modport master (input tap, output mole, output hit, output miss);
    modport slave  (output tap, input mole, input hit, input miss);

endinterface

// File: rtl/wam_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to choose the next mole hole.
module wam_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       clr,
    output logic [7:0] state
);
    import wam_pkg::*;

    // An all-zero seed would lock the register up.
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= SEED_EFF;
        end else begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/wam_mol.sv
// Mole generator and hit qualifier: lights one hole per round and grades taps against it.
//
//   state | meaning
//   GAP   | all moles dark, counting GAP_TICKS ticks
//   PICK  | one cycle, choose a hole different from the previous one
//   UP    | mole lit, waiting for a tap on its hole or LIFE_TICKS ticks
module wam_mol #(
    parameter int         LIFE_TICKS = 20,
    parameter int         GAP_TICKS  = 5,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick,
    input  logic       en,
    wam_mol_if.master  bus
);
    import wam_pkg::*;

    localparam int MAX_TICKS = (LIFE_TICKS > GAP_TICKS) ? LIFE_TICKS : GAP_TICKS;
    localparam int CW        = $clog2(MAX_TICKS) + 1;
    localparam logic [CW-1:0] LIFE_LAST = CW'(LIFE_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [HOLE_W-1:0]   hole;
    logic [HOLE_W-1:0]   next_hole;
    logic [7:0]          lfsr;
    logic [N_HOLE-1:0]   s1, s2, s3;
    logic [N_HOLE-1:0]   tap_edge;
    logic [N_HOLE-1:0]   mole_q;
    logic [N_HOLE-1:0]   hit_q;
    logic                miss_q;

    wam_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .clr   (clr),
        .state (lfsr)
    );

    // Taps are raw switch levels; any change of level counts as a strike.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= bus.tap;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tap_edge  = s2 ^ s3;
    assign next_hole = pick_hole(lfsr, hole);

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= GAP;
            cnt    <= '0;
            hole   <= '0;
            mole_q <= '0;
            hit_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            hit_q  <= '0;
            miss_q <= 1'b0;
            if (!en) begin
                state  <= GAP;
                cnt    <= '0;
                mole_q <= '0;
            end else begin
                case (state)
                    GAP: begin
                        mole_q <= '0;
                        if (tick) begin
                            if (cnt == GAP_LAST) begin
                                cnt   <= '0;
                                state <= PICK;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    PICK: begin
                        hole   <= next_hole;
                        mole_q <= N_HOLE'(1) << next_hole;
                        state  <= UP;
                    end
                    UP: begin
                        // A strike beats an expiry landing in the same cycle.
                        if (tap_edge[hole]) begin
                            hit_q  <= N_HOLE'(1) << hole;
                            mole_q <= '0;
                            cnt    <= '0;
                            state  <= GAP;
                        end else if (tick) begin
                            if (cnt == LIFE_LAST) begin
                                miss_q <= 1'b1;
                                mole_q <= '0;
                                cnt    <= '0;
                                state  <= GAP;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= GAP;
                        cnt    <= '0;
                        mole_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.mole = mole_q;
    assign bus.hit  = hit_q;
    assign bus.miss = miss_q;

endmodule

// File: tb/tb_wam_mol.sv
// Scoreboard bench for wam_mol: directed hit/miss/race/enable scenarios plus a seed-0 randomness run.
module tb_wam_mol;
    import wam_pkg::*;

    logic clk = 1'b0;
    logic clr, tick, en, en_z;
    logic run = 1'b0;

    always #5 clk = ~clk;

    wam_mol_if bus_a();
    wam_mol_if bus_z();

    wam_mol dut_a (.clk(clk), .clr(clr), .tick(tick), .en(en), .bus(bus_a));
    wam_mol #(.LFSR_SEED(8'h00)) dut_z (.clk(clk), .clr(clr), .tick(tick), .en(en_z), .bus(bus_z));

    typedef struct {
        logic [7:0] hit;
        logic       miss;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference LFSR, taps written out from the polynomial.
    function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [2:0] ref_hole(input logic [2:0] c, input logic [2:0] p);
        logic [2:0] n;
        n = c + 3'd1;
        return (c != p) ? c : n;
    endfunction

    logic [7:0] ma, ma_prev, mz, mz_prev;
    logic [2:0] pa, pz;

    always @(posedge clk) begin
        cyc++;
        ma_prev = ma;
        mz_prev = mz;
        if (clr) begin
            ma = 8'hA5;
            mz = 8'h01;
            pa = 3'd0;
            pz = 3'd0;
        end else begin
            ma = ref_lfsr(ma);
            mz = ref_lfsr(mz);
        end
    end

    // Monitor for the directed DUT.
    logic [7:0] last_a = 8'h00;
    logic [2:0] cur_a, ha;
    exp_t       e;

    always @(negedge clk) begin
        if (run) begin
            if (bus_a.hit != 8'h00 || bus_a.miss) begin
                chk("mole_dark_on_event", bus_a.mole, 0);
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: hit=%0h miss=%0b at cycle %0d, expected no event",
                             bus_a.hit, bus_a.miss, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("hit_value", bus_a.hit, e.hit);
                    chk("miss_value", bus_a.miss, e.miss);
                    chk("event_cycle", cyc, e.cyc);
                end
            end
            if (bus_a.mole != 8'h00 && last_a == 8'h00) begin
                ha    = ref_hole(ma_prev[2:0], pa);
                pa    = ha;
                cur_a = ha;
                chk("pick_hole_a", bus_a.mole, 8'(1) << ha);
            end
            last_a = bus_a.mole;
        end
    end

    // Monitor for the seed-0 DUT: never tapped, so every mole must expire.
    logic [7:0] last_z = 8'h00, lit_z = 8'h00, used_z = 8'h00;
    logic       miss_z_last = 1'b0;
    logic [2:0] hz;
    int         miss_z = 0;

    always @(negedge clk) begin
        if (run) begin
            chk("lfsr_nonzero", dut_z.lfsr != 8'h00, 1);
            if (bus_z.hit != 8'h00) chk("z_no_hit", bus_z.hit, 0);
            if (bus_z.miss) begin
                miss_z++;
                chk("z_mole_dark_on_miss", bus_z.mole, 0);
                chk("z_miss_one_cycle", miss_z_last, 0);
            end
            if (bus_z.mole != 8'h00 && last_z == 8'h00) begin
                hz = ref_hole(mz_prev[2:0], pz);
                pz = hz;
                chk("pick_hole_z", bus_z.mole, 8'(1) << hz);
                chk("z_no_repeat", bus_z.mole != lit_z, 1);
                lit_z  = bus_z.mole;
                used_z = used_z | bus_z.mole;
            end
            miss_z_last = bus_z.miss;
            last_z      = bus_z.mole;
        end
    end

    task automatic tick_once();
        @(posedge clk) #1 tick = 1'b1;
        @(posedge clk) #1 tick = 1'b0;
    endtask

    task automatic push(input logic [7:0] h, input logic m, input int c);
        exp_t x;
        x.hit  = h;
        x.miss = m;
        x.cyc  = c;
        sbq.push_back(x);
    endtask

    // Five GAP ticks, one PICK cycle, then the mole appears; returns the model's hole.
    task automatic gap_and_pick(output logic [2:0] h);
        repeat (4) tick_once();
        @(posedge clk) #1 chk("gap_dark", bus_a.mole, 0);
        tick_once();
        chk("pick_cycle_dark", bus_a.mole, 0);
        @(posedge clk);
        @(negedge clk);
        #1 chk("pick_after_5_ticks", bus_a.mole != 8'h00, 1);
        h = cur_a;
    endtask

    logic [2:0] h, w;

    initial begin
        clr       = 1'b1;
        tick      = 1'b0;
        en        = 1'b0;
        en_z      = 1'b1;
        bus_a.tap = 8'($urandom);
        bus_z.tap = 8'h00;
        @(posedge clk) #1 bus_a.tap = 8'($urandom);
        @(posedge clk) #1;
        chk("reset_mole", bus_a.mole, 0);
        chk("reset_hit", bus_a.hit, 0);
        chk("reset_miss", bus_a.miss, 0);
        chk("reset_mole_z", bus_z.mole, 0);
        clr = 1'b0;
        en  = 1'b1;
        run = 1'b1;

        gap_and_pick(h);
        chk("first_hole_not_0", bus_a.mole[0], 0);

        // Direct hits: tap change stable before edge k, hit registered on edge k+2.
        for (int i = 0; i < 2; i++) begin
            bus_a.tap[h] = ~bus_a.tap[h];
            push(8'(1) << h, 1'b0, cyc + 3);
            repeat (5) @(posedge clk);
            #1 chk("mole_dark_after_hit", bus_a.mole, 0);
            gap_and_pick(h);
        end

        // Wrong hole is ignored; mole expires after 20 ticks.
        w = h + 3'd3;
        bus_a.tap[w] = ~bus_a.tap[w];
        repeat (4) @(posedge clk);
        #1 chk("wrong_hole_mole_kept", bus_a.mole, 8'(1) << h);
        repeat (19) tick_once();
        chk("mole_lit_at_19", bus_a.mole, 8'(1) << h);
        @(posedge clk) #1;
        push(8'h00, 1'b1, cyc + 1);
        tick = 1'b1;
        @(posedge clk) #1 tick = 1'b0;
        chk("mole_dark_after_miss", bus_a.mole, 0);
        gap_and_pick(h);

        // Strike and expiring tick in the same cycle.
        repeat (19) tick_once();
        bus_a.tap[h] = ~bus_a.tap[h];
        push(8'(1) << h, 1'b0, cyc + 3);
        @(posedge clk) #1;
        @(posedge clk) #1 tick = 1'b1;
        @(posedge clk) #1 tick = 1'b0;
        @(posedge clk) #1 chk("mole_dark_after_race", bus_a.mole, 0);
        gap_and_pick(h);

        // Enable dropped mid-life: mole discarded silently, full gap after re-enable.
        repeat (7) tick_once();
        en = 1'b0;
        @(posedge clk) #1 chk("en_drop_mole_dark", bus_a.mole, 0);
        bus_a.tap[h] = ~bus_a.tap[h];
        repeat (2) tick_once();
        repeat (4) @(posedge clk);
        #1 chk("en_low_idle", bus_a.mole, 0);
        en = 1'b1;
        gap_and_pick(h);

        // Seed-0 unit runs 256 moles unattended; the directed unit is parked.
        en = 1'b0;
        for (int i = 0; i < 16000 && miss_z < 256; i++) begin
            tick_once();
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("z_miss_count", miss_z, 256);
        chk("z_all_holes_used", used_z, 8'hFF);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
